// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the single-clock AXI-Stream FIFO.
// Pointer width and parameter sanity checks.
package axis_fifo_pkg;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // True when depth is a power of two >= 4 and both thresholds are in range.
    function automatic bit cfg_ok(input int depth, input int af, input int ae);
        return (depth >= 4) && ((depth & (depth - 1)) == 0)
            && (af >= 1) && (af <= depth)
            && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/axis_fifo_ptr.sv
// Wrap-bit pointer pair with occupancy, threshold flags and flush.
// Owns every handshake decision; the top only stores data.
module axis_fifo_ptr
    import axis_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int PW        = ptr_w(FIFO_DEPTH)
) (
    input  logic          w_clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_req,
    input  logic          rd_req,
    output logic          wr_ready,
    output logic          wr_en,
    output logic          rd_en,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] raddr,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          almost_full,
    output logic          almost_empty
);

    if (!cfg_ok(FIFO_DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_cfg
        $error("axis_fifo_ptr: invalid depth or threshold parameters");
    end

    localparam logic [PW-1:0] AF_L = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_L = PW'(AE_THRESH);

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign level = wptr - rptr;

    assign almost_full  = (level >= AF_L);
    assign almost_empty = (level <= AE_L);

    // Flush blocks both handshakes so nothing moves in the clearing cycle.
    assign wr_ready = !full && !flush;
    assign wr_en    = wr_req && wr_ready;
    assign rd_en    = rd_req && !empty && !flush;

    assign waddr = wptr[AW-1:0];
    assign raddr = rptr[AW-1:0];

    // Write pointer: cleared by reset or flush, else advances per accepted word.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
        end else if (flush) begin
            wptr <= '0;
        end else if (wr_en) begin
            wptr <= wptr + 1'b1;
        end
    end

    // Read pointer: cleared by reset or flush, else advances per consumed word.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr <= '0;
        end else if (flush) begin
            rptr <= '0;
        end else if (rd_en) begin
            rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO, first-word-fall-through output.
// Storage array plus AXIS mapping around the pointer block.
module axis_sync_fifo
    import axis_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_WIDTH = 32,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  w_clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [FIFO_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [AW:0]           level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    typedef struct packed {
        logic                  tlast;
        logic [FIFO_WIDTH-1:0] tdata;
    } entry_t;

    entry_t          mem [FIFO_DEPTH];
    entry_t          head;
    logic            wr_en;
    logic            rd_en;
    logic [AW-1:0]   waddr;
    logic [AW-1:0]   raddr;
    logic            empty;
    logic            full;

    axis_fifo_ptr #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .AF_THRESH  (AF_THRESH),
        .AE_THRESH  (AE_THRESH)
    ) u_ptr (
        .w_clk        (w_clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_req       (s_axis_tvalid),
        .rd_req       (m_axis_tready),
        .wr_ready     (s_axis_tready),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .waddr        (waddr),
        .raddr        (raddr),
        .empty        (empty),
        .full         (full),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    // Storage holds no reset; validity is tracked purely by the pointers.
    always_ff @(posedge w_clk) begin
        if (wr_en) begin
            mem[waddr] <= '{tlast: s_axis_tlast, tdata: s_axis_tdata};
        end
    end

    assign head          = mem[raddr];
    assign m_axis_tdata  = head.tdata;
    assign m_axis_tlast  = head.tlast;
    assign m_axis_tvalid = !empty;

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Randomised scoreboard bench for axis_sync_fifo.
// Reference model is a plain queue of {tlast, tdata}.
module tb_axis_sync_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 32;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic             w_clk;
    logic             rst_n;
    logic             flush;
    logic [WIDTH-1:0] s_axis_tdata;
    logic             s_axis_tlast;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tlast;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [4:0]       level;
    logic             almost_full;
    logic             almost_empty;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH:0] exp_q [$];

    axis_sync_fifo #(
        .FIFO_DEPTH (DEPTH),
        .FIFO_WIDTH (WIDTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .w_clk         (w_clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .level         (level),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: queue semantics of the FIFO, updated per clock edge.
    always @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else begin
            int  sz;
            bit  rd;
            bit  wr;
            sz = exp_q.size();
            rd = m_axis_tready && (sz > 0);
            wr = s_axis_tvalid && (sz < DEPTH);
            if (rd) void'(exp_q.pop_front());
            if (wr) exp_q.push_back({s_axis_tlast, s_axis_tdata});
        end
    end

    // Monitor: compare every DUT output with the model mid-cycle.
    always @(negedge w_clk) begin
        int sz;
        sz = exp_q.size();
        chk("s_tready", s_axis_tready, (sz < DEPTH) && !flush);
        chk("m_tvalid", m_axis_tvalid, sz != 0);
        chk("level", level, sz);
        chk("almost_full", almost_full, sz >= AF);
        chk("almost_empty", almost_empty, sz <= AE);
        if (m_axis_tvalid && sz > 0) begin
            chk("head", {m_axis_tlast, m_axis_tdata}, exp_q[0]);
        end
    end

    task automatic drive(input logic v, input logic [WIDTH-1:0] d,
                         input logic l, input logic r, input logic f);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        m_axis_tready = r;
        flush         = f;
        @(posedge w_clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        #3;
        chk("rst_level", level, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tready", s_axis_tready, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);
        #9;
        rst_n = 1'b1;
        @(posedge w_clk);
        #1;

        // Fill with 0..15, no reads.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, WIDTH'(i), i == DEPTH - 1, 1'b0, 1'b0);
            if (i == 12) chk("af_before", almost_full, 0);
            if (i == 13) chk("af_at_14", almost_full, 1);
        end
        chk("fill_level", level, 16);
        chk("fill_tready", s_axis_tready, 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        chk("held_17th", level, 16);

        // Drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", m_axis_tdata, i);
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_tvalid", m_axis_tvalid, 0);

        // Full with simultaneous read and write attempt.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0);
        chk("full_rw_level", level, 15);
        chk("full_rw_tready", s_axis_tready, 1);
        for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("full_rw_empty", m_axis_tvalid, 0);

        // Write into empty: visible one edge later.
        drive(1'b1, 32'hA5, 1'b1, 1'b0, 1'b0);
        chk("lat_tvalid", m_axis_tvalid, 1);
        chk("lat_tdata", m_axis_tdata, 32'hA5);
        chk("lat_tlast", m_axis_tlast, 1);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Streaming at level 5.
        for (int i = 0; i < 5; i++) drive(1'b1, $urandom, 1'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, $urandom, 1'($urandom), 1'b1, 1'b0);
        end
        chk("stream_level", level, 5);

        // Flush at 7 entries with both handshakes active.
        for (int i = 0; i < 2; i++) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_level", level, 7);
        drive(1'b1, 32'hBEEF, 1'b0, 1'b1, 1'b1);
        chk("flush_level", level, 0);
        chk("flush_tvalid", m_axis_tvalid, 0);
        idle();
        chk("flush_no_store", level, 0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(9, 0) < 7, $urandom, 1'($urandom),
                  $urandom_range(9, 0) < 6, $urandom_range(31, 0) == 0);
        end

        // Build up then reset asynchronously mid-cycle.
        for (int i = 0; i < 6; i++) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", level, 0);
        chk("async_rst_tvalid", m_axis_tvalid, 0);
        chk("async_rst_ae", almost_empty, 1);
        @(posedge w_clk);
        #3;
        rst_n = 1'b1;
        @(posedge w_clk);
        #1;
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(1, 0) == 1, $urandom, 1'($urandom),
                  $urandom_range(1, 0) == 1, 1'b0);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
